// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared states, parameter field codes and frame-length helpers for the load sequencer
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_P,
    WAIT_GO,
    CALC,
    SCAN
  } nn_state_e;

  localparam logic [2:0] FIELD_TH = 3'd5;
  localparam logic [2:0] FIELD_B  = 3'd4;

  function automatic int fields_per_neuron(input int n_inputs);
    return n_inputs + 2;
  endfunction

  function automatic int p_frame_len(input int n_neurons, input int n_inputs);
    return n_neurons * fields_per_neuron(n_inputs);
  endfunction

  // Per-neuron byte k maps to: threshold, bias, then weights from the top index down.
  function automatic logic [2:0] field_of(input int k, input int n_inputs);
    if (k == 0) return FIELD_TH;
    if (k == 1) return FIELD_B;
    return 3'(n_inputs + 1 - k);
  endfunction

endpackage

// File: rtl/nn_frame_counter.sv
// rtl/nn_frame_counter.sv - nested neuron/field position counter for the parameter frame
module nn_frame_counter
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         step,
  output logic [$clog2(N_NEURONS)-1:0] neuron,
  output logic [2:0]                   field,
  output logic                         last
);

  localparam int FPN = fields_per_neuron(N_INPUTS);
  localparam int FW  = $clog2(FPN);
  localparam int NW  = $clog2(N_NEURONS);

  logic [FW-1:0] field_cnt_q, field_cnt_d;
  logic [NW-1:0] neuron_cnt_q, neuron_cnt_d;
  logic          field_end;

  assign field_end = (field_cnt_q == FW'(FPN - 1));
  assign last      = field_end && (neuron_cnt_q == NW'(N_NEURONS - 1));

  // Counts run upward from zero; the descending neuron/field order is a pure output mapping.
  always_comb begin
    field_cnt_d  = field_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    if (clear) begin
      field_cnt_d  = '0;
      neuron_cnt_d = '0;
    end else if (step) begin
      if (field_end) begin
        field_cnt_d  = '0;
        neuron_cnt_d = last ? '0 : neuron_cnt_q + 1'b1;
      end else begin
        field_cnt_d = field_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      field_cnt_q  <= '0;
      neuron_cnt_q <= '0;
    end else begin
      field_cnt_q  <= field_cnt_d;
      neuron_cnt_q <= neuron_cnt_d;
    end
  end

  assign neuron = NW'(N_NEURONS - 1) - neuron_cnt_q;
  assign field  = field_of(int'(field_cnt_q), N_INPUTS);

endmodule

// File: rtl/nn_load_sequencer.sv
// rtl/nn_load_sequencer.sv - byte-stream loader, compute start and result scan for neural_network
// Define NN_CALC_TIMEOUT_EN to bound the wait for calc_done by CALC_TIMEOUT cycles.
module nn_load_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int N_NEURONS    = 4,
  parameter int N_INPUTS     = 4,
  parameter int CALC_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         changes,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         in_ready,
  output logic                         x_we,
  output logic [$clog2(N_INPUTS)-1:0]  x_addr,
  output logic                         p_we,
  output logic [$clog2(N_NEURONS)-1:0] p_neuron,
  output logic [2:0]                   p_field,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         calc_start,
  input  logic                         calc_done,
  output logic [$clog2(N_NEURONS)-1:0] selector_output,
  input  logic [DATA_W-1:0]            network_outputs,
  output logic                         result_valid,
  output logic [DATA_W-1:0]            result_data,
  output logic [$clog2(N_NEURONS)-1:0] result_idx,
  output logic                         busy,
  output logic                         err_frame,
  output logic                         err_timeout
);

  localparam int XW = $clog2(N_INPUTS);
  localparam int NW = $clog2(N_NEURONS);

  if (N_INPUTS < 2 || N_INPUTS + 1 > int'(FIELD_TH) || N_NEURONS < 2 || CALC_TIMEOUT < 1
      || p_frame_len(N_NEURONS, N_INPUTS) < N_NEURONS) begin : g_bad_cfg
    $error("nn_load_sequencer: unsupported parameter set");
  end

  nn_state_e         state_q;
  logic              changes_q;
  logic [XW-1:0]     x_cnt_q;
  logic              x_we_q;
  logic [XW-1:0]     x_addr_q;
  logic              p_we_q;
  logic [NW-1:0]     p_neuron_q;
  logic [2:0]        p_field_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              calc_start_q;
  logic [NW-1:0]     sel_q;
  logic              result_valid_q;
  logic [DATA_W-1:0] result_data_q;
  logic [NW-1:0]     result_idx_q;
  logic              err_frame_q;

  logic              ev_w;
  logic              accept_w;
  logic [NW-1:0]     fc_neuron;
  logic [2:0]        fc_field;
  logic              fc_last;

`ifdef NN_CALC_TIMEOUT_EN
  localparam int CW = $clog2(CALC_TIMEOUT + 1);
  logic [CW-1:0]     calc_cnt_q;
  logic              err_timeout_q;
`endif

  assign ev_w     = changes & ~changes_q;
  assign in_ready = (state_q == LOAD_X) || (state_q == LOAD_P);
  assign accept_w = in_valid & in_ready;
  assign busy     = (state_q != IDLE);

  nn_frame_counter #(
    .N_NEURONS (N_NEURONS),
    .N_INPUTS  (N_INPUTS)
  ) u_frame_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != LOAD_P),
    .step   ((state_q == LOAD_P) && accept_w && !ev_w),
    .neuron (fc_neuron),
    .field  (fc_field),
    .last   (fc_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      changes_q      <= 1'b0;
      x_cnt_q        <= '0;
      x_we_q         <= 1'b0;
      x_addr_q       <= '0;
      p_we_q         <= 1'b0;
      p_neuron_q     <= '0;
      p_field_q      <= '0;
      wr_data_q      <= '0;
      calc_start_q   <= 1'b0;
      sel_q          <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      result_idx_q   <= '0;
      err_frame_q    <= 1'b0;
`ifdef NN_CALC_TIMEOUT_EN
      calc_cnt_q     <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      changes_q      <= changes;
      x_we_q         <= 1'b0;
      p_we_q         <= 1'b0;
      calc_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_w) begin
            state_q     <= LOAD_X;
            x_cnt_q     <= '0;
            err_frame_q <= 1'b0;
`ifdef NN_CALC_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
          end
        end
        // A new frame edge mid-load aborts; a byte accepted in the same cycle is dropped.
        LOAD_X: begin
          if (ev_w) begin
            err_frame_q <= 1'b1;
            x_cnt_q     <= '0;
            state_q     <= IDLE;
          end else if (accept_w) begin
            x_we_q    <= 1'b1;
            x_addr_q  <= XW'(N_INPUTS - 1) - x_cnt_q;
            wr_data_q <= data_in;
            if (x_cnt_q == XW'(N_INPUTS - 1)) begin
              x_cnt_q <= '0;
              state_q <= LOAD_P;
            end else begin
              x_cnt_q <= x_cnt_q + 1'b1;
            end
          end
        end
        LOAD_P: begin
          if (ev_w) begin
            err_frame_q <= 1'b1;
            state_q     <= IDLE;
          end else if (accept_w) begin
            p_we_q     <= 1'b1;
            p_neuron_q <= fc_neuron;
            p_field_q  <= fc_field;
            wr_data_q  <= data_in;
            if (fc_last) state_q <= WAIT_GO;
          end
        end
        WAIT_GO: begin
          if (ev_w) begin
            state_q      <= CALC;
            calc_start_q <= 1'b1;
`ifdef NN_CALC_TIMEOUT_EN
            calc_cnt_q   <= '0;
`endif
          end
        end
        CALC: begin
          if (calc_done) begin
            state_q <= SCAN;
            sel_q   <= '0;
          end
`ifdef NN_CALC_TIMEOUT_EN
          else if (calc_cnt_q == CW'(CALC_TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            calc_cnt_q    <= '0;
            state_q       <= IDLE;
          end else begin
            calc_cnt_q <= calc_cnt_q + 1'b1;
          end
`endif
        end
        // The mux settles during the cycle sel_q is presented; capture it at the following edge.
        SCAN: begin
          result_valid_q <= 1'b1;
          result_data_q  <= network_outputs;
          result_idx_q   <= sel_q;
          if (sel_q == NW'(N_NEURONS - 1)) begin
            sel_q   <= '0;
            state_q <= IDLE;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_we            = x_we_q;
  assign x_addr          = x_addr_q;
  assign p_we            = p_we_q;
  assign p_neuron        = p_neuron_q;
  assign p_field         = p_field_q;
  assign wr_data         = wr_data_q;
  assign calc_start      = calc_start_q;
  assign selector_output = sel_q;
  assign result_valid    = result_valid_q;
  assign result_data     = result_data_q;
  assign result_idx      = result_idx_q;
  assign err_frame       = err_frame_q;
`ifdef NN_CALC_TIMEOUT_EN
  assign err_timeout     = err_timeout_q;
`else
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_nn_load_sequencer.sv
// tb/tb_nn_load_sequencer.sv - directed self-checking bench for nn_load_sequencer
module tb_nn_load_sequencer;

  logic       clk = 1'b0;
  logic       reset, changes, in_valid, calc_done;
  logic [7:0] data_in, network_outputs;
  logic       in_ready, x_we, p_we, calc_start, result_valid, busy, err_frame, err_timeout;
  logic [1:0] x_addr, p_neuron, selector_output, result_idx;
  logic [2:0] p_field;
  logic [7:0] wr_data, result_data;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int rv_count = 0;
  int rv0;
  logic [15:0] x_log[$];
  logic [15:0] p_log[$];
  logic [7:0]  net_tbl[4];

  always #5 clk = ~clk;

  assign network_outputs = net_tbl[selector_output];

  nn_load_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .changes         (changes),
    .in_valid        (in_valid),
    .data_in         (data_in),
    .in_ready        (in_ready),
    .x_we            (x_we),
    .x_addr          (x_addr),
    .p_we            (p_we),
    .p_neuron        (p_neuron),
    .p_field         (p_field),
    .wr_data         (wr_data),
    .calc_start      (calc_start),
    .calc_done       (calc_done),
    .selector_output (selector_output),
    .network_outputs (network_outputs),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .result_idx      (result_idx),
    .busy            (busy),
    .err_frame       (err_frame),
    .err_timeout     (err_timeout)
  );

  always @(negedge clk) begin
    if (x_we) x_log.push_back({6'd0, x_addr, wr_data});
    if (p_we) p_log.push_back({3'd0, p_neuron, p_field, wr_data});
    if (result_valid) rv_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_changes();
    changes = 1'b1;
    tick();
    changes = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    data_in  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Parameter byte k: neuron 3-k/6, field 5-k%6; th=0, b=5, w3..w0=4..1, neuron 0 b/w all 1.
  function automatic logic [7:0] param_byte(input int k);
    int n;
    int f;
    n = 3 - k / 6;
    f = k % 6;
    if (f == 0) return 8'd0;
    if (n == 0) return 8'd1;
    if (f == 1) return 8'd5;
    return 8'(6 - f);
  endfunction

  task automatic load_frame(input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(8'(10 - i));
    for (int k = 0; k < 24; k++) begin
      send_byte(param_byte(k));
      if (gaps) tick();
    end
    tick();
  endtask

  task automatic verify_frame(input string tag);
    logic [15:0] e;
    chk({tag, "_xcount"}, x_log.size(), 4);
    for (int i = 0; i < 4 && i < x_log.size(); i++) begin
      e = {6'd0, 2'(3 - i), 8'(10 - i)};
      chk({tag, "_xwrite"}, x_log[i], e);
    end
    chk({tag, "_pcount"}, p_log.size(), 24);
    for (int k = 0; k < 24 && k < p_log.size(); k++) begin
      e = {3'd0, 2'(3 - k / 6), 3'(5 - k % 6), param_byte(k)};
      chk({tag, "_pwrite"}, p_log[k], e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    net_tbl[0] = 8'h11;
    net_tbl[1] = 8'h22;
    net_tbl[2] = 8'h33;
    net_tbl[3] = 8'h44;
    reset = 1'b1; changes = 1'b0; in_valid = 1'b0; data_in = 8'h00; calc_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", {x_we, p_we, calc_start, result_valid}, 0);
    chk("rst_err", {err_frame, err_timeout}, 0);
    chk("rst_sel", selector_output, 0);
    reset = 1'b0;
    tick();

    // 1: nominal frame
    pulse_changes();
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(10 - i));
      chk("t1_x_we_lat", x_we, 1);
      chk("t1_x_addr", x_addr, 3 - i);
      chk("t1_x_data", wr_data, 10 - i);
    end
    for (int k = 0; k < 24; k++) send_byte(param_byte(k));
    tick();
    chk("t1_wait_in_ready", in_ready, 0);
    chk("t1_wait_busy", busy, 1);
    chk("t1_p_we_done", p_we, 0);
    verify_frame("t1");

    // 2: start, done, scan
    rv0 = rv_count;
    pulse_changes();
    chk("t2_calc_start", calc_start, 1);
    tick();
    chk("t2_calc_start_1cyc", calc_start, 0);
    tick();
    tick();
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    chk("t2_sel0", selector_output, 0);
    chk("t2_rv_before", result_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_rv", result_valid, 1);
      chk("t2_idx", result_idx, i);
      chk("t2_data", result_data, net_tbl[i]);
      chk("t2_sel", selector_output, (i + 1) % 4);
    end
    chk("t2_idle", busy, 0);
    tick();
    chk("t2_rv_after", result_valid, 0);
    chk("t2_rv_pulses", rv_count - rv0, 4);

    // 3: abort after 10 parameter bytes, concurrent byte dropped
    x_log.delete();
    p_log.delete();
    pulse_changes();
    for (int i = 0; i < 4; i++) send_byte(8'(10 - i));
    for (int k = 0; k < 10; k++) send_byte(param_byte(k));
    changes = 1'b1; in_valid = 1'b1; data_in = 8'hEE;
    tick();
    changes = 1'b0; in_valid = 1'b0;
    chk("t3_no_strobe", p_we, 0);
    chk("t3_err_frame", err_frame, 1);
    chk("t3_idle", busy, 0);
    chk("t3_in_ready", in_ready, 0);
    tick();
    chk("t3_pcount", p_log.size(), 10);
    send_byte(8'h55);
    tick();
    chk("t3_idle_ignore_x", x_log.size(), 4);
    chk("t3_idle_ignore_p", p_log.size(), 10);
    chk("t3_err_sticky", err_frame, 1);
    x_log.delete();
    p_log.delete();
    pulse_changes();
    chk("t3_err_cleared", err_frame, 0);
    chk("t3_busy", busy, 1);

    // 4: gapped parameter stream
    load_frame(1'b1);
    chk("t4_wait_in_ready", in_ready, 0);
    verify_frame("t4");

    // 5: reset in CALC
    pulse_changes();
    chk("t5_calc_start", calc_start, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_strobes", {x_we, p_we, calc_start, result_valid}, 0);
    chk("t5_wr_data", wr_data, 0);
    chk("t5_result", {result_data, 6'd0, result_idx}, 0);
    chk("t5_sel", selector_output, 0);
    rv0 = rv_count;
    calc_done = 1'b1;
    tick();
    tick();
    calc_done = 1'b0;
    chk("t5_done_ignored", busy, 0);
    chk("t5_no_scan", rv_count - rv0, 0);

    // 6: calc timeout
    x_log.delete();
    p_log.delete();
    pulse_changes();
    load_frame(1'b0);
    rv0 = rv_count;
    pulse_changes();
`ifdef NN_CALC_TIMEOUT_EN
    repeat (63) tick();
    chk("t6_still_calc", busy, 1);
    chk("t6_no_timeout_yet", err_timeout, 0);
    tick();
    chk("t6_timeout_idle", busy, 0);
    chk("t6_err_timeout", err_timeout, 1);
    tick();
    chk("t6_no_results", rv_count - rv0, 0);
    pulse_changes();
    chk("t6_err_cleared", err_timeout, 0);
`else
    repeat (70) tick();
    chk("t6_waits", busy, 1);
    chk("t6_err_tied", err_timeout, 0);
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    repeat (5) tick();
    chk("t6_late_scan", rv_count - rv0, 4);
    chk("t6_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
